// File: rtl/line_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// line_buffer_ctrl
//
// Initiator for a 1W/2R synchronous line RAM. Each accepted raster pixel is
// written into the RAM slot of the current line while the same column of the
// two previous lines is read. One cycle later an aligned 3-row column
// {top = row r-2, mid = row r-1, bot = row r} is presented downstream.
//
// The RAM holds two lines (two banks of LINE_W_P entries). The bank being
// written holds row r-2 before the write. Read-before-write on port b returns
// that old row, and the slot is then overwritten with row r. Port a reads the
// other bank, which holds row r-1.
//
// Ports
//   clk_i, rstn_i              clock, synchronous active-low reset
//   pix_i, pix_sof_i           input pixel and start-of-frame flag
//   pix_valid_i, pix_ready_o   input handshake
//   col_valid_o, col_ready_i   output column handshake
//   top_o, mid_o, bot_o        rows r-2 / r-1 / r of the emitted column
//   col_x_o                    column index of the emitted column
//   rows_ok_o                  top_o/mid_o hold real data (row >= 2)
//   ram_*                      line RAM write/read addresses, enables, data
// ----------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter  int WIDTH_P  = 8,
    parameter  int LINE_W_P = 640,
    localparam int AW_P     = $clog2(2*LINE_W_P),
    localparam int CW_P     = $clog2(LINE_W_P)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [WIDTH_P-1:0] pix_i,
    input  logic               pix_sof_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    output logic               col_valid_o,
    input  logic               col_ready_i,
    output logic [WIDTH_P-1:0] top_o,
    output logic [WIDTH_P-1:0] mid_o,
    output logic [WIDTH_P-1:0] bot_o,
    output logic [CW_P-1:0]    col_x_o,
    output logic               rows_ok_o,
    output logic [WIDTH_P-1:0] ram_data_o,
    output logic [AW_P-1:0]    ram_wr_addr_o,
    output logic [AW_P-1:0]    ram_rd_addr_a_o,
    output logic [AW_P-1:0]    ram_rd_addr_b_o,
    output logic               ram_wr_en_o,
    output logic               ram_rd_en_a_o,
    output logic               ram_rd_en_b_o,
    input  logic [WIDTH_P-1:0] ram_data_a_i,
    input  logic [WIDTH_P-1:0] ram_data_b_i
);

    // Raster position counters; row saturates at 2 (only "row >= 2" matters).
    logic [CW_P-1:0]    r_col;
    logic [1:0]         r_row;
    logic               r_bank;

    // Output column register
    logic               r_valid;
    logic [WIDTH_P-1:0] r_bot;
    logic [CW_P-1:0]    r_col_x;
    logic               r_rows_ok;

    logic               w_ready;
    logic               w_accept;
    logic [CW_P-1:0]    w_col_eff;
    logic [1:0]         w_row_eff;
    logic               w_bank_eff;
    logic               w_last;
    logic [CW_P-1:0]    w_col_nxt;
    logic [1:0]         w_row_nxt;
    logic               w_bank_nxt;
    logic [AW_P-1:0]    w_col_addr;

    // Ready is blocked during reset so nothing is accepted while rstn_i is low.
    assign w_ready  = rstn_i & (~r_valid | col_ready_i);
    assign w_accept = pix_valid_i & w_ready;

    always_comb begin
        // A start-of-frame pixel is placed at col 0, row 0, bank 0
        // regardless of where the counters currently stand.
        w_col_eff  = r_col;
        w_row_eff  = r_row;
        w_bank_eff = r_bank;
        if (pix_sof_i) begin
            w_col_eff  = '0;
            w_row_eff  = '0;
            w_bank_eff = 1'b0;
        end

        w_last     = (w_col_eff == CW_P'(LINE_W_P - 1));
        w_col_nxt  = w_col_eff + CW_P'(1);
        w_row_nxt  = w_row_eff;
        w_bank_nxt = w_bank_eff;
        if (w_last) begin
            w_col_nxt  = '0;
            w_bank_nxt = ~w_bank_eff;
            if (w_row_eff != 2'd2) begin
                w_row_nxt = w_row_eff + 2'd1;
            end
        end

        w_col_addr = AW_P'(w_col_eff);
    end

    // Write slot and port-b read share the current bank (row r-2 slot);
    // port a reads the opposite bank (row r-1).
    assign ram_wr_addr_o   = w_col_addr + (w_bank_eff ? AW_P'(LINE_W_P) : '0);
    assign ram_rd_addr_b_o = ram_wr_addr_o;
    assign ram_rd_addr_a_o = w_col_addr + (w_bank_eff ? '0 : AW_P'(LINE_W_P));
    assign ram_wr_en_o     = w_accept;
    assign ram_rd_en_a_o   = w_accept;
    assign ram_rd_en_b_o   = w_accept;
    assign ram_data_o      = pix_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_col     <= '0;
            r_row     <= '0;
            r_bank    <= 1'b0;
            r_valid   <= 1'b0;
            r_bot     <= '0;
            r_col_x   <= '0;
            r_rows_ok <= 1'b0;
        end else if (w_accept) begin
            // Accept replaces any column being handed off this cycle, so
            // back-to-back transfers see no bubble.
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_bank    <= w_bank_nxt;
            r_valid   <= 1'b1;
            r_bot     <= pix_i;
            r_col_x   <= w_col_eff;
            r_rows_ok <= (w_row_eff == 2'd2);
        end else if (col_ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign pix_ready_o = w_ready;
    assign col_valid_o = r_valid;
    assign bot_o       = r_bot;
    assign col_x_o     = r_col_x;
    assign rows_ok_o   = r_rows_ok;
    // RAM outputs hold while no read is enabled, so these stay frozen on stall.
    assign top_o       = ram_data_b_i;
    assign mid_o       = ram_data_a_i;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_line_buffer_ctrl
//
// Bench for line_buffer_ctrl with LINE_W_P = 4. Contains a read-before-write
// 1W/2R RAM model, a golden row-history model that pushes the expected column
// on every accepted pixel, and a monitor that pops and compares on every
// output handshake. Directed checks cover reset, stall, bank toggle, SOF
// restart and mid-line reset; a random valid/ready phase covers 3 frames.
// ----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int AW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic [W-1:0]  pix_i;
    logic          pix_sof_i;
    logic          pix_valid_i;
    logic          pix_ready_o;
    logic          col_valid_o;
    logic          col_ready_i;
    logic [W-1:0]  top_o, mid_o, bot_o;
    logic [CW-1:0] col_x_o;
    logic          rows_ok_o;
    logic [W-1:0]  ram_data_o;
    logic [AW-1:0] ram_wr_addr_o, ram_rd_addr_a_o, ram_rd_addr_b_o;
    logic          ram_wr_en_o, ram_rd_en_a_o, ram_rd_en_b_o;
    logic [W-1:0]  ram_data_a_i = '0;
    logic [W-1:0]  ram_data_b_i = '0;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.WIDTH_P(W), .LINE_W_P(L)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .pix_i           (pix_i),
        .pix_sof_i       (pix_sof_i),
        .pix_valid_i     (pix_valid_i),
        .pix_ready_o     (pix_ready_o),
        .col_valid_o     (col_valid_o),
        .col_ready_i     (col_ready_i),
        .top_o           (top_o),
        .mid_o           (mid_o),
        .bot_o           (bot_o),
        .col_x_o         (col_x_o),
        .rows_ok_o       (rows_ok_o),
        .ram_data_o      (ram_data_o),
        .ram_wr_addr_o   (ram_wr_addr_o),
        .ram_rd_addr_a_o (ram_rd_addr_a_o),
        .ram_rd_addr_b_o (ram_rd_addr_b_o),
        .ram_wr_en_o     (ram_wr_en_o),
        .ram_rd_en_a_o   (ram_rd_en_a_o),
        .ram_rd_en_b_o   (ram_rd_en_b_o),
        .ram_data_a_i    (ram_data_a_i),
        .ram_data_b_i    (ram_data_b_i)
    );

    // Line RAM model: 1-cycle read latency, read-before-write, holds when idle.
    logic [W-1:0] mem [0:2*L-1];
    initial for (int i = 0; i < 2*L; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_rd_en_a_o) ram_data_a_i <= mem[ram_rd_addr_a_o];
        if (ram_rd_en_b_o) ram_data_b_i <= mem[ram_rd_addr_b_o];
        if (ram_wr_en_o)   mem[ram_wr_addr_o] <= ram_data_o;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Golden model: previous two rows of the current frame, by column.
    typedef struct {
        logic [W-1:0]  top;
        logic [W-1:0]  mid;
        logic [W-1:0]  bot;
        logic [CW-1:0] x;
        logic          ok;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] prev1 [L];
    logic [W-1:0] prev2 [L];
    logic [W-1:0] cur   [L];
    int           m_col = 0;
    int           m_row = 0;

    always @(negedge clk) begin : push_p
        exp_t e;
        if (!rstn_i) begin
            m_col = 0;
            m_row = 0;
            sb.delete();
        end else if (pix_valid_i && pix_ready_o) begin
            if (pix_sof_i) begin
                m_col = 0;
                m_row = 0;
            end
            e.top = prev2[m_col];
            e.mid = prev1[m_col];
            e.bot = pix_i;
            e.x   = m_col[CW-1:0];
            e.ok  = (m_row >= 2);
            sb.push_back(e);
            cur[m_col] = pix_i;
            if (m_col == L-1) begin
                prev2 = prev1;
                prev1 = cur;
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
    end

    always @(negedge clk) begin : mon_p
        exp_t e;
        if (rstn_i && col_valid_o && col_ready_i) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow: got column x=%0d bot=%0d, expected none", col_x_o, bot_o);
            end else begin
                e = sb.pop_front();
                chk("sb_col_x", col_x_o, e.x);
                chk("sb_rows_ok", rows_ok_o, e.ok);
                chk("sb_bot", bot_o, e.bot);
                if (e.ok) begin
                    chk("sb_top", top_o, e.top);
                    chk("sb_mid", mid_o, e.mid);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] p, input logic s);
        int t;
        pix_i       = p;
        pix_sof_i   = s;
        pix_valid_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!pix_ready_o && t < 100);
        if (!pix_ready_o) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: pixel %0d ready=0, expected ready=1", p);
        end
        @(posedge clk);
        #1;
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, expected completion");
        $fatal(1, "watchdog");
    end

    logic done;

    initial begin
        rstn_i      = 1'b0;
        pix_i       = '0;
        pix_sof_i   = 1'b0;
        pix_valid_i = 1'b0;
        col_ready_i = 1'b1;
        done        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col_valid", col_valid_o, 0);
        chk("rst_pix_ready", pix_ready_o, 0);
        chk("rst_bot", bot_o, 0);
        chk("rst_col_x", col_x_o, 0);
        chk("rst_rows_ok", rows_ok_o, 0);
        chk("rst_wr_en", ram_wr_en_o, 0);
        rstn_i = 1'b1;

        // Rows 0,1 then row 2 col 0
        for (int p = 1; p <= 9; p++) send(8'(p), 1'b0);
        chk("r2c0_top", top_o, 1);
        chk("r2c0_mid", mid_o, 5);
        chk("r2c0_bot", bot_o, 9);
        chk("r2c0_rows_ok", rows_ok_o, 1);

        // Stall downstream for 3 cycles with a pixel pending
        col_ready_i = 1'b0;
        pix_i       = 8'd10;
        pix_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_pix_ready", pix_ready_o, 0);
            chk("stall_wr_en", ram_wr_en_o, 0);
            chk("stall_rd_en_a", ram_rd_en_a_o, 0);
            chk("stall_rd_en_b", ram_rd_en_b_o, 0);
            chk("stall_valid", col_valid_o, 1);
            chk("stall_top", top_o, 1);
            chk("stall_mid", mid_o, 5);
            chk("stall_bot", bot_o, 9);
        end
        @(posedge clk);
        #1;
        col_ready_i = 1'b1;
        for (int p = 10; p <= 16; p++) send(8'(p), 1'b0);
        chk("r3c3_top", top_o, 8);
        chk("r3c3_mid", mid_o, 12);
        chk("r3c3_bot", bot_o, 16);
        chk("r3c3_col_x", col_x_o, 3);

        // SOF in the middle of a row-2+ line
        send(8'd17, 1'b0);
        pix_i       = 8'd18;
        pix_sof_i   = 1'b1;
        pix_valid_i = 1'b1;
        @(negedge clk);
        chk("sof_wr_en", ram_wr_en_o, 1);
        chk("sof_wr_addr", ram_wr_addr_o, 0);
        chk("sof_rd_addr_b", ram_rd_addr_b_o, 0);
        chk("sof_rd_addr_a", ram_rd_addr_a_o, 4);
        @(posedge clk);
        #1;
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        chk("sof_col_x", col_x_o, 0);
        chk("sof_rows_ok", rows_ok_o, 0);
        for (int p = 19; p <= 25; p++) send(8'(p), 1'b0);
        chk("sof_r1c3_rows_ok", rows_ok_o, 0);
        send(8'd26, 1'b0);
        chk("sof_r2c0_rows_ok", rows_ok_o, 1);
        chk("sof_r2c0_top", top_o, 18);
        chk("sof_r2c0_mid", mid_o, 22);

        // Reset in the middle of a line with an output pending
        for (int p = 27; p <= 31; p++) send(8'(p), 1'b0);
        chk("prerst_valid", col_valid_o, 1);
        rstn_i      = 1'b0;
        col_ready_i = 1'b0;
        pix_i       = 8'd99;
        pix_valid_i = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", col_valid_o, 0);
        chk("midrst_pix_ready", pix_ready_o, 0);
        chk("midrst_wr_en", ram_wr_en_o, 0);
        @(posedge clk);
        #1;
        rstn_i      = 1'b1;
        col_ready_i = 1'b1;
        pix_i       = 8'd40;
        @(negedge clk);
        chk("postrst_wr_en", ram_wr_en_o, 1);
        chk("postrst_wr_addr", ram_wr_addr_o, 0);
        chk("postrst_rd_addr_a", ram_rd_addr_a_o, 4);
        @(posedge clk);
        #1;
        pix_valid_i = 1'b0;
        chk("postrst_col_x", col_x_o, 0);
        chk("postrst_bot", bot_o, 40);
        chk("postrst_rows_ok", rows_ok_o, 0);

        // Random valid/ready toggling over 3 frames
        fork
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    col_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 3*L; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send(8'($urandom_range(0, 255)), (k == 0));
                    end
                end
                done = 1'b1;
            end
        join
        col_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_sb_depth", sb.size(), 0);
        chk("drain_valid", col_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
